fm_sb_trig_ctrl: RTL and testbench
==================================

# fm_sb_trig_ctrl

Parametrised spy-buffer control block for the fast-monitoring (FM) spy system, succeeding the fixed 64-channel freeze/playback controller. It drives per-spy-buffer freeze and playback-mode lines for any channel count, with full-width masks, and adds a trigger-driven delayed freeze (post-trigger window) and a timed spy-memory initialisation sweep. It sits between the FM AXI control registers and the spy-buffer instances, in the AXI clock domain.

## Interface
Parameters:
- SB_N, 80, number of spy buffers controlled (≥1)
- AXI_DW, 32, register word width; masks are MASK_W = ceil(SB_N/AXI_DW)*AXI_DW bits
- PB_MODE_W, 2, playback-mode width
- POST_W, 16, post-trigger counter width
- INIT_AW, 10, spy-memory address width; sweep length 2^INIT_AW cycles

Ports:
- axi_clk  in  1  clock
- axi_reset  in  1  synchronous, active-high reset
- global_freeze  in  1  software freeze level
- global_pb_mode  in  PB_MODE_W  software playback mode
- freeze_mask  in  MASK_W  bit i=1 excludes channel i from freeze
- playback_mask  in  MASK_W  bit i=1 forces channel i playback mode to 0
- trig_en  in  1  arms trigger freeze; low forces FSM to IDLE
- trig_in  in  1  single-cycle trigger pulse
- rearm  in  1  single-cycle pulse, FROZEN → IDLE
- post_trig  in  POST_W  post-trigger cycles before freeze
- init_req  in  1  initialisation request level (rising edge acts)
- freeze  out  SB_N  per-channel freeze
- playback_mode  out  SB_N*PB_MODE_W  per-channel mode, channel i at [i*PB_MODE_W +: PB_MODE_W]
- init_spy_mem  out  1  high during initialisation sweep
- init_addr  out  INIT_AW  sweep address
- trig_state  out  2  0=IDLE, 1=COUNTING, 2=FROZEN
- post_cnt  out  POST_W  remaining post-trigger cycles

## Operation
- Reset: all outputs 0, FSM IDLE, sweep idle, init_req edge detector cleared (init_req high at reset release does not start a sweep).
- Freeze request: frz_req = global_freeze | (trig_state==FROZEN). freeze[i] <= frz_req & ~freeze_mask[i]. Mask bits ≥ SB_N ignored. Every channel is covered by its own mask bit.
- Playback: playback_mode[i] <= playback_mask[i] ? 0 : global_pb_mode, bit-indexed per channel (mask bit i, for all i).
- Trigger FSM:
  - IDLE: trig_en & trig_in: post_trig==0 → FROZEN; else → COUNTING, post_cnt <= post_trig.
  - COUNTING: post_cnt==1 → FROZEN, post_cnt <= 0; else post_cnt decrements. trig_in ignored (no retrigger).
  - FROZEN: held until rearm → IDLE. rearm and trig_in in the same cycle: rearm wins, trigger discarded.
  - trig_en low in any state → IDLE next edge, post_cnt <= 0; takes precedence over all other transitions.
  - rearm outside FROZEN: no effect.
- Init sweep: rising edge of init_req while idle starts sweep: init_spy_mem=1, init_addr steps 0 … 2^INIT_AW−1, one per cycle, then init_spy_mem=0, init_addr=0. Rising edge during sweep ignored (no restart).
- During sweep: freeze all 1s (masks ignored), playback_mode all 0s; trigger FSM keeps running. Masked values return on the edge init_spy_mem falls.
- Reset mid-sweep or mid-count aborts to reset values.

## Timing
- All outputs registered, 1-cycle latency from global_freeze, global_pb_mode, masks.
- trig_in sampled at edge T, post_trig=P: trig_state=FROZEN from T+1+P; freeze rises at T+2+P (unmasked channels, global_freeze low).
- trig_en low sampled at edge T: trig_state=IDLE at T+1; freeze falls at T+2 if global_freeze low.
- init_req rising edge sampled at edge T: init_spy_mem, freeze all-ones, init_addr=0 at T+1; last address 2^INIT_AW−1 at T+2^INIT_AW; init_spy_mem low at T+2^INIT_AW+1.

## Test plan
- SB_N=80, global_freeze=1, freeze_mask bits 5 and 70 set → freeze = all ones except bits 5 and 70, one cycle later; bits 64–79 respond (no >64 truncation).
- global_pb_mode=2'b10, playback_mask bit 40 set → playback_mode channel 40 = 0, all others 2'b10; bit 33 unset stays 2'b10 (per-bit indexing).
- trig_en=1, post_trig=5, trig_in at T → post_cnt 5,4,3,2,1 over T+1..T+5, FROZEN at T+6, freeze high at T+7; second trig_in at T+3 changes nothing.
- FROZEN with rearm and trig_in same cycle → IDLE next edge, no new count; then trig_en drop during COUNTING (post_trig=100) → IDLE, post_cnt=0, freeze never asserts.
- INIT_AW=4, init_req 0→1 → init_spy_mem high 16 cycles, init_addr 0..15, freeze all-ones, playback 0; extra init_req edge at cycle 8 ignored; masked outputs restored after.
- axi_reset pulsed mid-sweep at addr 7 and mid-count → all outputs 0 next edge, IDLE, init_req still high does not restart sweep.

Source files
------------

// File: rtl/fm_sb_trig_ctrl.sv
// Spy-buffer freeze/playback controller for the FM spy system: per-channel masked
// freeze and playback mode, trigger-delayed freeze, and a timed spy-memory init sweep.
module fm_sb_trig_ctrl #(
  parameter int SB_N      = 80,
  parameter int AXI_DW    = 32,
  parameter int PB_MODE_W = 2,
  parameter int POST_W    = 16,
  parameter int INIT_AW   = 10,
  localparam int MASK_W   = ((SB_N + AXI_DW - 1) / AXI_DW) * AXI_DW
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic                      global_freeze,
  input  logic [PB_MODE_W-1:0]      global_pb_mode,
  input  logic [MASK_W-1:0]         freeze_mask,
  input  logic [MASK_W-1:0]         playback_mask,
  input  logic                      trig_en,
  input  logic                      trig_in,
  input  logic                      rearm,
  input  logic [POST_W-1:0]         post_trig,
  input  logic                      init_req,
  output logic [SB_N-1:0]           freeze,
  output logic [SB_N*PB_MODE_W-1:0] playback_mode,
  output logic                      init_spy_mem,
  output logic [INIT_AW-1:0]        init_addr,
  output logic [1:0]                trig_state,
  output logic [POST_W-1:0]         post_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COUNTING = 2'd1;
  localparam logic [1:0] ST_FROZEN   = 2'd2;
  localparam logic [INIT_AW-1:0] ADDR_LAST = {INIT_AW{1'b1}};

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic [POST_W-1:0]         r_post_cnt;
  logic [POST_W-1:0]         w_post_cnt_nxt;
  logic                      r_init;
  logic                      w_init_nxt;
  logic [INIT_AW-1:0]        r_addr;
  logic [INIT_AW-1:0]        w_addr_nxt;
  logic                      r_init_req_d;
  logic                      w_init_rise;
  logic                      w_frz_req;
  logic [SB_N-1:0]           r_freeze;
  logic [SB_N-1:0]           w_freeze_nxt;
  logic [SB_N*PB_MODE_W-1:0] r_pb;
  logic [SB_N*PB_MODE_W-1:0] w_pb_nxt;

  // Trigger FSM state and post-trigger counter registers
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state    <= ST_IDLE;
      r_post_cnt <= {POST_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_post_cnt <= w_post_cnt_nxt;
    end
  end

  // Trigger FSM next state; trig_en low overrides everything, rearm beats a same-cycle trigger
  always_comb begin
    w_state_nxt    = r_state;
    w_post_cnt_nxt = r_post_cnt;
    if (!trig_en) begin
      w_state_nxt    = ST_IDLE;
      w_post_cnt_nxt = {POST_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (trig_in) begin
            if (post_trig == {POST_W{1'b0}}) begin
              w_state_nxt    = ST_FROZEN;
              w_post_cnt_nxt = {POST_W{1'b0}};
            end else begin
              w_state_nxt    = ST_COUNTING;
              w_post_cnt_nxt = post_trig;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_COUNTING: begin
          if (r_post_cnt <= POST_W'(1)) begin
            w_state_nxt    = ST_FROZEN;
            w_post_cnt_nxt = {POST_W{1'b0}};
          end else begin
            w_post_cnt_nxt = r_post_cnt - POST_W'(1);
          end
        end
        ST_FROZEN: begin
          if (rearm) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FROZEN;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_post_cnt_nxt = {POST_W{1'b0}};
        end
      endcase
    end
  end

  // Sweep sequencing and per-channel freeze/playback; the sweep overrides the masks
  always_comb begin
    w_frz_req   = global_freeze | (r_state == ST_FROZEN);
    w_init_rise = init_req & ~r_init_req_d;
    w_init_nxt  = r_init;
    w_addr_nxt  = r_addr;
    if (r_init) begin
      if (r_addr == ADDR_LAST) begin
        w_init_nxt = 1'b0;
        w_addr_nxt = {INIT_AW{1'b0}};
      end else begin
        w_addr_nxt = r_addr + INIT_AW'(1);
      end
    end else if (w_init_rise) begin
      w_init_nxt = 1'b1;
      w_addr_nxt = {INIT_AW{1'b0}};
    end else begin
      w_init_nxt = 1'b0;
    end
    w_freeze_nxt = {SB_N{1'b0}};
    w_pb_nxt     = {(SB_N*PB_MODE_W){1'b0}};
    if (w_init_nxt) begin
      w_freeze_nxt = {SB_N{1'b1}};
    end else begin
      for (int i = 0; i < SB_N; i++) begin
        w_freeze_nxt[i] = w_frz_req & ~freeze_mask[i];
        w_pb_nxt[i*PB_MODE_W +: PB_MODE_W] =
          playback_mask[i] ? {PB_MODE_W{1'b0}} : global_pb_mode;
      end
    end
  end

  // Output and sweep registers; the edge detector loads init_req so a level held through reset is not an edge
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_init       <= 1'b0;
      r_addr       <= {INIT_AW{1'b0}};
      r_init_req_d <= init_req;
      r_freeze     <= {SB_N{1'b0}};
      r_pb         <= {(SB_N*PB_MODE_W){1'b0}};
    end else begin
      r_init       <= w_init_nxt;
      r_addr       <= w_addr_nxt;
      r_init_req_d <= init_req;
      r_freeze     <= w_freeze_nxt;
      r_pb         <= w_pb_nxt;
    end
  end

  generate
    if (MASK_W > SB_N) begin : g_mask_pad
      logic w_unused_mask_hi;
      assign w_unused_mask_hi = ^{freeze_mask[MASK_W-1:SB_N], playback_mask[MASK_W-1:SB_N]};
    end
  endgenerate

  assign freeze        = r_freeze;
  assign playback_mode = r_pb;
  assign init_spy_mem  = r_init;
  assign init_addr     = r_addr;
  assign trig_state    = r_state;
  assign post_cnt      = r_post_cnt;

endmodule

// File: tb/tb_fm_sb_trig_ctrl.sv
// Scoreboard bench for fm_sb_trig_ctrl: stimulus queues cycle-tagged expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_fm_sb_trig_ctrl;

  localparam int SB_N   = 80;
  localparam int MASK_W = 96;
  localparam int K_FRZ = 0, K_PB = 1, K_INIT = 2, K_ADDR = 3, K_ST = 4, K_CNT = 5;

  logic          axi_clk;
  logic          axi_reset;
  logic          global_freeze;
  logic [1:0]    global_pb_mode;
  logic [MASK_W-1:0] freeze_mask;
  logic [MASK_W-1:0] playback_mask;
  logic          trig_en;
  logic          trig_in;
  logic          rearm;
  logic [15:0]   post_trig;
  logic          init_req;
  logic [79:0]   freeze;
  logic [159:0]  playback_mode;
  logic          init_spy_mem;
  logic [3:0]    init_addr;
  logic [1:0]    trig_state;
  logic [15:0]   post_cnt;

  fm_sb_trig_ctrl #(.SB_N(80), .AXI_DW(32), .PB_MODE_W(2), .POST_W(16), .INIT_AW(4)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .global_freeze(global_freeze),
    .global_pb_mode(global_pb_mode), .freeze_mask(freeze_mask), .playback_mask(playback_mask),
    .trig_en(trig_en), .trig_in(trig_in), .rearm(rearm), .post_trig(post_trig),
    .init_req(init_req), .freeze(freeze), .playback_mode(playback_mode),
    .init_spy_mem(init_spy_mem), .init_addr(init_addr), .trig_state(trig_state),
    .post_cnt(post_cnt)
  );

  typedef struct {
    int           cyc;
    int           kind;
    logic [159:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [79:0]  all1;
  logic [79:0]  frz_m;
  logic [79:0]  frz_79;
  logic [159:0] pb_m;
  logic [159:0] pb_01;

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;
  always @(posedge axi_clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_FRZ:   return "freeze";
      K_PB:    return "playback_mode";
      K_INIT:  return "init_spy_mem";
      K_ADDR:  return "init_addr";
      K_ST:    return "trig_state";
      K_CNT:   return "post_cnt";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [159:0] actual(input int k);
    case (k)
      K_FRZ:   return 160'(freeze);
      K_PB:    return playback_mode;
      K_INIT:  return 160'(init_spy_mem);
      K_ADDR:  return 160'(init_addr);
      K_ST:    return 160'(trig_state);
      K_CNT:   return 160'(post_cnt);
      default: return 160'd0;
    endcase
  endfunction

  task automatic exp_at(input int off, input int kind, input logic [159:0] val);
    exp_t e;
    e.cyc  = cyc + off;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  // Monitor: compare every expectation due in the current cycle
  always @(negedge axi_clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        logic [159:0] a;
        a = actual(q[i].kind);
        vectors = vectors + 1;
        if (a !== q[i].val) begin
          miscompares = miscompares + 1;
          $display("FAIL %s cycle %0d: got %h, expected %h", kname(q[i].kind), cyc, a, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    all1   = {80{1'b1}};
    frz_m  = all1; frz_m[5] = 1'b0; frz_m[70] = 1'b0;
    frz_79 = all1; frz_79[79] = 1'b0;
    pb_01  = {80{2'b01}};
    pb_m   = {80{2'b10}}; pb_m[81:80] = 2'b00;

    axi_reset = 1'b1; global_freeze = 1'b1; global_pb_mode = 2'b11;
    freeze_mask = '0; playback_mask = '0; trig_en = 1'b0; trig_in = 1'b0;
    rearm = 1'b0; post_trig = 16'd0; init_req = 1'b0;

    // reset state while inputs are active
    step(1);
    exp_at(1, K_FRZ, 160'd0); exp_at(1, K_PB, 160'd0); exp_at(1, K_INIT, 160'd0);
    exp_at(1, K_ADDR, 160'd0); exp_at(1, K_ST, 160'd0); exp_at(1, K_CNT, 160'd0);
    step(2);
    vectors = vectors + 1;
    if (freeze !== 80'd0 || trig_state !== 2'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset direct: freeze %h trig_state %0d", freeze, trig_state);
    end
    axi_reset = 1'b0;

    // masked freeze across the full width, per-bit playback mask
    freeze_mask[5] = 1'b1; freeze_mask[70] = 1'b1; freeze_mask[90] = 1'b1;
    global_pb_mode = 2'b10; playback_mask[40] = 1'b1;
    exp_at(1, K_FRZ, 160'(frz_m)); exp_at(1, K_PB, pb_m);
    step(1);
    vectors = vectors + 1;
    if (freeze !== frz_m || playback_mode !== pb_m) begin
      miscompares = miscompares + 1;
      $display("FAIL mask direct: freeze %h playback_mode %h", freeze, playback_mode);
    end
    freeze_mask = '0; freeze_mask[79] = 1'b1;
    exp_at(1, K_FRZ, 160'(frz_79));
    step(1);
    vectors = vectors + 1;
    if (freeze !== frz_79) begin
      miscompares = miscompares + 1;
      $display("FAIL bit79 direct: freeze %h", freeze);
    end
    global_freeze = 1'b0; freeze_mask = '0; playback_mask = '0; global_pb_mode = 2'b01;
    exp_at(1, K_FRZ, 160'd0); exp_at(1, K_PB, pb_01);
    step(1);
    vectors = vectors + 1;
    if (freeze !== 80'd0 || playback_mode !== pb_01) begin
      miscompares = miscompares + 1;
      $display("FAIL release direct: freeze %h playback_mode %h", freeze, playback_mode);
    end

    // trigger with post_trig=5, retrigger during count ignored
    trig_en = 1'b1; post_trig = 16'd5; trig_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      exp_at(k, K_CNT, 160'(6 - k)); exp_at(k, K_ST, 160'd1);
    end
    exp_at(6, K_ST, 160'd2); exp_at(6, K_CNT, 160'd0); exp_at(6, K_FRZ, 160'd0);
    exp_at(7, K_FRZ, 160'(all1));
    step(1); trig_in = 1'b0;
    step(1); trig_in = 1'b1;
    step(1); trig_in = 1'b0;
    step(5);

    // rearm and trig_in together in FROZEN: rearm wins
    rearm = 1'b1; trig_in = 1'b1;
    exp_at(0, K_ST, 160'd2); exp_at(1, K_ST, 160'd0); exp_at(1, K_FRZ, 160'(all1));
    exp_at(2, K_ST, 160'd0); exp_at(2, K_CNT, 160'd0); exp_at(2, K_FRZ, 160'd0);
    step(1); rearm = 1'b0; trig_in = 1'b0;
    step(2);

    // post_trig=0 freezes immediately
    post_trig = 16'd0; trig_in = 1'b1;
    exp_at(1, K_ST, 160'd2); exp_at(1, K_CNT, 160'd0); exp_at(2, K_FRZ, 160'(all1));
    step(1); trig_in = 1'b0; rearm = 1'b1;
    exp_at(1, K_ST, 160'd0);
    step(1); rearm = 1'b0;
    step(1);

    // rearm in IDLE has no effect; then trig_en drop from FROZEN
    post_trig = 16'd3; trig_in = 1'b1; rearm = 1'b1;
    exp_at(1, K_ST, 160'd1); exp_at(1, K_CNT, 160'd3); exp_at(4, K_ST, 160'd2);
    step(1); trig_in = 1'b0; rearm = 1'b0;
    step(4);
    trig_en = 1'b0;
    exp_at(1, K_ST, 160'd0); exp_at(1, K_FRZ, 160'(all1)); exp_at(2, K_FRZ, 160'd0);
    step(2); trig_en = 1'b1;
    step(1);

    // trig_en drop during a long count
    post_trig = 16'd100; trig_in = 1'b1;
    exp_at(1, K_ST, 160'd1); exp_at(1, K_CNT, 160'd100);
    step(1); trig_in = 1'b0;
    step(3);
    exp_at(0, K_CNT, 160'd97);
    trig_en = 1'b0;
    exp_at(1, K_ST, 160'd0); exp_at(1, K_CNT, 160'd0);
    exp_at(1, K_FRZ, 160'd0); exp_at(2, K_FRZ, 160'd0);
    step(2); trig_en = 1'b1;
    step(1);

    // init sweep over 16 addresses, extra edge mid-sweep ignored
    global_freeze = 1'b1; freeze_mask[5] = 1'b1; freeze_mask[70] = 1'b1;
    global_pb_mode = 2'b10; playback_mask[40] = 1'b1;
    step(1);
    init_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      exp_at(k, K_INIT, 160'd1); exp_at(k, K_ADDR, 160'(k - 1));
      exp_at(k, K_FRZ, 160'(all1)); exp_at(k, K_PB, 160'd0);
    end
    exp_at(17, K_INIT, 160'd0); exp_at(17, K_ADDR, 160'd0);
    exp_at(17, K_FRZ, 160'(frz_m)); exp_at(17, K_PB, pb_m);
    exp_at(18, K_INIT, 160'd0); exp_at(20, K_INIT, 160'd0);
    step(6); init_req = 1'b0;
    step(1); init_req = 1'b1;
    step(14); init_req = 1'b0;
    step(1);

    // reset mid-sweep (addr 7) and mid-count
    init_req = 1'b1; post_trig = 16'd50; trig_in = 1'b1;
    exp_at(8, K_ADDR, 160'd7); exp_at(8, K_ST, 160'd1); exp_at(8, K_CNT, 160'd43);
    step(1); trig_in = 1'b0;
    step(7);
    axi_reset = 1'b1;
    exp_at(1, K_FRZ, 160'd0); exp_at(1, K_PB, 160'd0); exp_at(1, K_INIT, 160'd0);
    exp_at(1, K_ADDR, 160'd0); exp_at(1, K_ST, 160'd0); exp_at(1, K_CNT, 160'd0);
    step(1); axi_reset = 1'b0;
    exp_at(1, K_INIT, 160'd0); exp_at(1, K_FRZ, 160'(frz_m)); exp_at(1, K_PB, pb_m);
    exp_at(1, K_ST, 160'd0); exp_at(3, K_INIT, 160'd0); exp_at(3, K_ADDR, 160'd0);
    step(6);

    foreach (q[i]) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL %s unchecked at cycle %0d: got nothing, expected %h", kname(q[i].kind), q[i].cyc, q[i].val);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
